// File: rtl/counter_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// counter_cmd_arbiter
//
// Run-control sequencer for the 0-9999 up/down counter datapath. Merges the
// three debounced push-button levels and decoded UART receive bytes into one
// enable/clear/mode control set, and owns the STOP/RUN/CLEAR state machine.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low (0 = reset)
//   btn_enable  debounced level; rising edge = run/stop toggle
//   btn_clear   debounced level; rising edge = clear
//   btn_mode    debounced level; rising edge = up/down toggle
//   rx_data     received UART byte, qualified by rx_done
//   rx_done     one-cycle strobe for rx_data
//   enable      datapath count enable (registered)
//   clear       datapath synchronous clear (registered)
//   mode        0 = count up, 1 = count down (registered)
//   state       current state for LEDs: STOP=00, RUN=01, CLEAR=10
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_STOP  | counter halted; run -> ST_RUN, clear -> ST_CLEAR
//   ST_RUN   | counter counting; run -> ST_STOP, clear -> ST_CLEAR
//   ST_CLEAR | clear held CLEAR_CYCLES cycles, then -> ST_STOP;
//            | run/clear commands ignored, mode toggles still applied
// -----------------------------------------------------------------------------
module counter_cmd_arbiter #(
  parameter logic [7:0]  CMD_RUN      = 8'h52,
  parameter logic [7:0]  CMD_CLEAR    = 8'h43,
  parameter logic [7:0]  CMD_MODE     = 8'h4D,
  parameter int unsigned CLEAR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_enable,
  input  logic       btn_clear,
  input  logic       btn_mode,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       enable,
  output logic       clear,
  output logic       mode,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    C_NONE  = 2'b00,
    C_RUN   = 2'b01,
    C_CLEAR = 2'b10,
    C_MODE  = 2'b11
  } cmd_t;

  localparam logic [7:0] CLEAR_LOAD = 8'(CLEAR_CYCLES);

  state_t     state_q;
  logic       enable_q;
  logic       clear_q;
  logic       mode_q;
  logic [7:0] clr_cnt_q;

  logic       prev_enable_q;
  logic       prev_clear_q;
  logic       prev_mode_q;

  logic       pend_valid_q;
  cmd_t       pend_cmd_q;
  logic       pend_valid_d;
  cmd_t       pend_cmd_d;

  logic       evt_run;
  logic       evt_clear;
  logic       evt_mode;
  logic       btn_any;

  cmd_t       rx_cmd;
  cmd_t       sel_cmd;
  logic       win_run;
  logic       win_clear;
  logic       win_mode;

  // Button rising edges against last cycle's sample.
  assign evt_run   = btn_enable & ~prev_enable_q;
  assign evt_clear = btn_clear  & ~prev_clear_q;
  assign evt_mode  = btn_mode   & ~prev_mode_q;
  assign btn_any   = evt_run | evt_clear | evt_mode;

  // UART decode accepts the upper-case code or its lower-case twin.
  always_comb begin
    rx_cmd = C_NONE;
    if (rx_done) begin
      if (rx_data == CMD_RUN || rx_data == (CMD_RUN | 8'h20)) begin
        rx_cmd = C_RUN;
      end else if (rx_data == CMD_CLEAR || rx_data == (CMD_CLEAR | 8'h20)) begin
        rx_cmd = C_CLEAR;
      end else if (rx_data == CMD_MODE || rx_data == (CMD_MODE | 8'h20)) begin
        rx_cmd = C_MODE;
      end
    end
  end

  // Arbitration: buttons first, then the pending UART entry, then a fresh
  // UART command. A UART command that loses the cycle lands in the 1-entry
  // buffer and replaces whatever was there.
  always_comb begin
    win_run      = 1'b0;
    win_clear    = 1'b0;
    win_mode     = 1'b0;
    sel_cmd      = C_NONE;
    pend_valid_d = pend_valid_q;
    pend_cmd_d   = pend_cmd_q;

    if (btn_any) begin
      win_clear = evt_clear;
      win_run   = evt_run & ~evt_clear;
      win_mode  = evt_mode;
      if (rx_cmd != C_NONE) begin
        pend_valid_d = 1'b1;
        pend_cmd_d   = rx_cmd;
      end
    end else if (pend_valid_q) begin
      sel_cmd = pend_cmd_q;
      // A command decoded while the old entry drains becomes the new entry.
      pend_valid_d = (rx_cmd != C_NONE);
      pend_cmd_d   = rx_cmd;
    end else begin
      sel_cmd = rx_cmd;
    end

    if (!btn_any) begin
      win_run   = (sel_cmd == C_RUN);
      win_clear = (sel_cmd == C_CLEAR);
      win_mode  = (sel_cmd == C_MODE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_STOP;
      enable_q      <= 1'b0;
      clear_q       <= 1'b0;
      mode_q        <= 1'b0;
      clr_cnt_q     <= 8'd0;
      prev_enable_q <= 1'b0;
      prev_clear_q  <= 1'b0;
      prev_mode_q   <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_cmd_q    <= C_NONE;
    end else begin
      prev_enable_q <= btn_enable;
      prev_clear_q  <= btn_clear;
      prev_mode_q   <= btn_mode;
      pend_valid_q  <= pend_valid_d;
      pend_cmd_q    <= pend_cmd_d;

      if (win_mode) begin
        mode_q <= ~mode_q;
      end

      case (state_q)
        ST_STOP, ST_RUN: begin
          if (win_clear) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= CLEAR_LOAD;
            enable_q  <= 1'b0;
            clear_q   <= 1'b1;
          end else if (win_run) begin
            if (state_q == ST_STOP) begin
              state_q  <= ST_RUN;
              enable_q <= 1'b1;
            end else begin
              state_q  <= ST_STOP;
              enable_q <= 1'b0;
            end
            clear_q <= 1'b0;
          end
        end

        ST_CLEAR: begin
          // Terminal count of 1 closes the hold window; <= guards a zero load.
          if (clr_cnt_q <= 8'd1) begin
            state_q   <= ST_STOP;
            clr_cnt_q <= 8'd0;
            enable_q  <= 1'b0;
            clear_q   <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q - 8'd1;
          end
        end

        default: begin
          state_q   <= ST_STOP;
          clr_cnt_q <= 8'd0;
          enable_q  <= 1'b0;
          clear_q   <= 1'b0;
        end
      endcase
    end
  end

  assign enable = enable_q;
  assign clear  = clear_q;
  assign mode   = mode_q;
  assign state  = state_q;

endmodule
